// File: rtl/reg_ctx_sequencer.sv
// reg_ctx_sequencer: register file context save/restore engine with a LIFO context stack; define CTX_CLEAR_EN to zero registers while saving.
module reg_ctx_sequencer #(
  parameter int WORD_SIZE = 8,
  parameter int REG_SIZE  = 4,
  parameter int DEPTH     = 2,
  localparam int ADDR_W   = $clog2(REG_SIZE),
  localparam int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 save_req,
  input  logic                 restore_req,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [WORD_SIZE-1:0] rd_data,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [WORD_SIZE-1:0] wr_data,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LVL_W-1:0]     ctx_level,
  output logic                 ctx_full,
  output logic                 ctx_empty
);
  localparam int SW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REG_SIZE - 1);
  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [LVL_W-1:0] lvl_n;
  logic err_n;
  logic [SW-1:0] sv_slot, rs_slot;
  logic [WORD_SIZE-1:0] stack [DEPTH][REG_SIZE];
  assign sv_slot = SW'(ctx_level);
  assign rs_slot = SW'(ctx_level - LVL_W'(1));
  assign busy = state == SAVE || state == RESTORE;
  assign done = state == DONE;
  assign rd_addr = state == SAVE ? idx : '0;
`ifdef CTX_CLEAR_EN
  assign wr_en = busy;
`else
  assign wr_en = state == RESTORE;
`endif
  assign wr_addr = wr_en ? idx : '0;
  assign wr_data = state == RESTORE ? stack[rs_slot][idx] : '0;
  always_comb begin
    state_n = state;
    idx_n = idx;
    lvl_n = ctx_level;
    err_n = 1'b0;
    case (state)
      IDLE:
        if (save_req) begin
          err_n = ctx_full;
          state_n = ctx_full ? IDLE : SAVE;
          idx_n = '0;
        end else if (restore_req) begin
          err_n = ctx_empty;
          state_n = ctx_empty ? IDLE : RESTORE;
          idx_n = '0;
        end
      DONE: state_n = IDLE;
      default: begin
        idx_n = idx + ADDR_W'(1);
        if (idx == LAST) begin
          state_n = DONE;
          lvl_n = state == SAVE ? ctx_level + LVL_W'(1) : ctx_level - LVL_W'(1);
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      ctx_level <= '0;
      ctx_full <= 1'b0;
      ctx_empty <= 1'b1;
      err <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      ctx_level <= lvl_n;
      ctx_full <= lvl_n == FULL;
      ctx_empty <= lvl_n == '0;
      err <= err_n;
    end
  end
  always_ff @(posedge clk)
    if (state == SAVE) stack[sv_slot][idx] <= rd_data;
endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// tb_reg_ctx_sequencer: scoreboard bench with a register file model around reg_ctx_sequencer.
module tb_reg_ctx_sequencer;
  logic clk = 0, rst = 1, save_req = 0, restore_req = 0;
  logic [1:0] rd_addr, wr_addr, ctx_level;
  logic [7:0] rd_data, wr_data;
  logic wr_en, busy, done, err, ctx_full, ctx_empty;
  logic [7:0] regs [4];
  logic tb_ld = 0;
  logic [31:0] tb_vals = 0;
  int total = 0, bad = 0;
`ifdef CTX_CLEAR_EN
  localparam bit CLR = 1;
`else
  localparam bit CLR = 0;
`endif
  typedef struct packed {
    logic b, d, e, w;
    logic [1:0] ra, wa;
    logic [7:0] wd;
    logic [1:0] lvl;
  } ev_t;
  ev_t q [$];
  ev_t got, ex;

  reg_ctx_sequencer dut (
    .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .busy(busy), .done(done), .err(err),
    .ctx_level(ctx_level), .ctx_full(ctx_full), .ctx_empty(ctx_empty)
  );

  always #5 clk = ~clk;
  assign rd_data = regs[rd_addr];
  always @(posedge clk)
    if (wr_en) regs[wr_addr] <= wr_data;
    else if (tb_ld) for (int i = 0; i < 4; i++) regs[i] <= tb_vals[8*i+:8];

  assign got = {busy, done, err, wr_en, rd_addr, wr_addr, wr_data, ctx_level};
  always @(negedge clk)
    if (busy | done | err | wr_en) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=%h", got);
      end else begin
        ex = q.pop_front();
        if (got !== ex) begin
          bad++;
          $display("FAIL event got=%h exp=%h", got, ex);
        end
      end
    end

  function automatic ev_t mk(logic b, d, e, w, logic [1:0] ra, wa, logic [7:0] wd, logic [1:0] l);
    return {b, d, e, w, ra, wa, wd, l};
  endfunction

  task automatic exp_save(input logic [1:0] l);
    for (int i = 0; i < 4; i++) q.push_back(mk(1, 0, 0, CLR, 2'(i), CLR ? 2'(i) : 2'd0, 8'h00, l));
    q.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, l + 2'd1));
  endtask

  task automatic exp_restore(input logic [1:0] l, input logic [31:0] v);
    for (int i = 0; i < 4; i++) q.push_back(mk(1, 0, 0, 1, 0, 2'(i), v[8*i+:8], l));
    q.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, l - 2'd1));
  endtask

  task automatic exp_err(input logic [1:0] l);
    q.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, l));
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic chk_regs(input string n, input logic [31:0] e);
    chk(n, {regs[3], regs[2], regs[1], regs[0]}, e);
  endtask

  task automatic load(input logic [31:0] v);
    @(negedge clk);
    tb_vals = v;
    tb_ld = 1;
    @(negedge clk);
    tb_ld = 0;
  endtask

  task automatic pulse(input logic s, input logic r);
    @(negedge clk);
    save_req = s;
    restore_req = r;
    @(negedge clk);
    save_req = 0;
    restore_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(3);
    rst = 0;
    chk("reset_status", {busy, done, err, wr_en, ctx_full, ctx_empty}, 6'b000001);
    chk("reset_level", ctx_level, 0);
    chk("reset_ports", {rd_addr, wr_addr, wr_data}, 0);
    load(32'hDDCCBBAA);
    exp_save(0);
    pulse(1, 0);
    idle(6);
    chk("save1_level", {ctx_level, ctx_full, ctx_empty}, {2'd1, 2'b00});
    chk_regs("save1_regs", CLR ? 32'h0 : 32'hDDCCBBAA);
    load(32'h44332211);
    exp_restore(1, 32'hDDCCBBAA);
    pulse(0, 1);
    idle(6);
    chk("restore1_level", {ctx_level, ctx_full, ctx_empty}, {2'd0, 2'b01});
    chk_regs("restore1_regs", 32'hDDCCBBAA);
    exp_save(0);
    pulse(1, 0);
    idle(6);
    load(32'h04030201);
    exp_save(1);
    pulse(1, 0);
    idle(6);
    chk("nest_full", {ctx_level, ctx_full, ctx_empty}, {2'd2, 2'b10});
    exp_err(2);
    pulse(1, 0);
    idle(3);
    chk("overflow_level", ctx_level, 2);
    exp_restore(2, 32'h04030201);
    pulse(0, 1);
    idle(6);
    chk_regs("nest_restore1_regs", 32'h04030201);
    exp_restore(1, 32'hDDCCBBAA);
    pulse(0, 1);
    idle(6);
    chk_regs("nest_restore2_regs", 32'hDDCCBBAA);
    chk("nest_empty", {ctx_level, ctx_full, ctx_empty}, {2'd0, 2'b01});
    exp_err(0);
    pulse(0, 1);
    idle(3);
    chk("underflow_level", {ctx_level, ctx_empty}, {2'd0, 1'b1});
    exp_save(0);
    pulse(1, 1);
    idle(6);
    chk("both_req_level", ctx_level, 1);
    q.push_back(mk(1, 0, 0, CLR, 2'd0, 2'd0, 8'h00, 2'd1));
    q.push_back(mk(1, 0, 0, CLR, 2'd1, CLR ? 2'd1 : 2'd0, 8'h00, 2'd1));
    pulse(1, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_state", {busy, done, ctx_level, ctx_empty}, {2'b00, 2'd0, 1'b1});
    idle(5);
    exp_err(0);
    pulse(0, 1);
    idle(3);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
